// File: rtl/traffic_light_monitor.sv
// Watches the two-road lamp outputs, rebuilds the phase, counts down the cycles
// left in each phase and latches the first encoding/order/duration violation.
module traffic_light_monitor #(
  parameter int unsigned LEN_AG = 8,
  parameter int unsigned LEN_Y  = 3,
  parameter int unsigned LEN_BG = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] LightA,
  input  logic [2:0] LightB,
  input  logic       fault_clr,
  output logic [1:0] phase,
  output logic [3:0] remain,
  output logic       locked,
  output logic       cycle_done,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam logic [3:0] LEN_AG_W = 4'(LEN_AG);
  localparam logic [3:0] LEN_Y_W  = 4'(LEN_Y);
  localparam logic [3:0] LEN_BG_W = 4'(LEN_BG);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_ILLEGAL = 3'd1;
  localparam logic [2:0] CODE_ORDER   = 3'd2;
  localparam logic [2:0] CODE_SHORT   = 3'd3;
  localparam logic [2:0] CODE_LONG    = 3'd4;

  typedef enum logic [1:0] {
    MODE_SYNC   = 2'd0,
    MODE_LOCKED = 2'd1,
    MODE_FAULT  = 2'd2
  } mode_e;

  mode_e      mode_q, mode_d;
  logic [1:0] prev_q, prev_d;
  logic       seen_q, seen_d;
  logic [3:0] run_q, run_d;
  logic [1:0] phase_q, phase_d;
  logic [3:0] remain_q, remain_d;
  logic       locked_q, locked_d;
  logic       cycle_done_q, cycle_done_d;
  logic       fault_q, fault_d;
  logic [2:0] code_q, code_d;

  logic       legal_c;
  logic [1:0] p_c;
  logic [2:0] det_c;
  logic [3:0] run_inc_c;
  logic [1:0] nxt_c;

  function automatic logic [3:0] len_of(input logic [1:0] ph);
    case (ph)
      2'd0:    len_of = LEN_AG_W;
      2'd2:    len_of = LEN_BG_W;
      default: len_of = LEN_Y_W;
    endcase
  endfunction

  // Lamp pair decode; anything outside the four legal pairs is illegal
  always_comb begin
    legal_c = 1'b1;
    p_c     = 2'd0;
    case ({LightA, LightB})
      6'b001_100: p_c = 2'd0;
      6'b010_100: p_c = 2'd1;
      6'b100_001: p_c = 2'd2;
      6'b100_010: p_c = 2'd3;
      default:    legal_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_SYNC;
      prev_q       <= 2'd0;
      seen_q       <= 1'b0;
      run_q        <= 4'd0;
      phase_q      <= 2'd0;
      remain_q     <= 4'd0;
      locked_q     <= 1'b0;
      cycle_done_q <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= CODE_NONE;
    end else begin
      mode_q       <= mode_d;
      prev_q       <= prev_d;
      seen_q       <= seen_d;
      run_q        <= run_d;
      phase_q      <= phase_d;
      remain_q     <= remain_d;
      locked_q     <= locked_d;
      cycle_done_q <= cycle_done_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    prev_d       = prev_q;
    seen_d       = seen_q;
    run_d        = run_q;
    phase_d      = phase_q;
    cycle_done_d = 1'b0;
    fault_d      = fault_q;
    code_d       = code_q;
    det_c        = CODE_NONE;
    run_inc_c    = (run_q == 4'hF) ? run_q : run_q + 4'd1;
    nxt_c        = prev_q + 2'd1;

    if (fault_clr) begin
      // Clear wins over anything detected on this edge; the sample is dropped
      fault_d = 1'b0;
      code_d  = CODE_NONE;
      mode_d  = MODE_SYNC;
      seen_d  = 1'b0;
    end else if (!legal_c) begin
      det_c = CODE_ILLEGAL;
    end else begin
      phase_d = p_c;
      case (mode_q)
        MODE_SYNC: begin
          if (!seen_q) begin
            seen_d = 1'b1;
            prev_d = p_c;
            run_d  = 4'd1;
          end else if (p_c == prev_q) begin
            run_d = run_inc_c;
          end else if (p_c == nxt_c) begin
            mode_d = MODE_LOCKED;
            prev_d = p_c;
            run_d  = 4'd1;
          end else begin
            det_c = CODE_ORDER;
          end
        end
        MODE_LOCKED: begin
          if (p_c == prev_q) begin
            if (run_q == len_of(prev_q)) det_c = CODE_LONG;
            else                         run_d = run_inc_c;
          end else if (p_c != nxt_c) begin
            det_c = CODE_ORDER;
          end else if (run_q < len_of(prev_q)) begin
            det_c = CODE_SHORT;
          end else begin
            prev_d       = p_c;
            run_d        = 4'd1;
            cycle_done_d = (prev_q == 2'd3);
          end
        end
        default: begin
          prev_d = p_c;
          run_d  = (p_c == prev_q) ? run_inc_c : 4'd1;
        end
      endcase

      // A faulting legal sample is still tracked like any sample in FAULT
      if (det_c != CODE_NONE) begin
        prev_d = p_c;
        run_d  = (p_c == prev_q) ? run_inc_c : 4'd1;
      end
    end

    if (det_c != CODE_NONE) begin
      mode_d = MODE_FAULT;
      if (!fault_q) begin
        fault_d = 1'b1;
        code_d  = det_c;
      end
    end

    locked_d = (mode_d == MODE_LOCKED);
    remain_d = locked_d ? (len_of(prev_d) - run_d) : 4'd0;
  end

  assign phase      = phase_q;
  assign remain     = remain_q;
  assign locked     = locked_q;
  assign cycle_done = cycle_done_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: nominal cycles, each fault class,
// clear/fault collision and a mid-run reset, with hand-computed expectations.
module tb_traffic_light_monitor;

  logic       clk;
  logic       reset;
  logic [2:0] LightA;
  logic [2:0] LightB;
  logic       fault_clr;
  logic [1:0] phase;
  logic [3:0] remain;
  logic       locked;
  logic       cycle_done;
  logic       fault;
  logic [2:0] fault_code;

  int checks;
  int errors;

  traffic_light_monitor #(.LEN_AG(8), .LEN_Y(3), .LEN_BG(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .LightA     (LightA),
    .LightB     (LightB),
    .fault_clr  (fault_clr),
    .phase      (phase),
    .remain     (remain),
    .locked     (locked),
    .cycle_done (cycle_done),
    .fault      (fault),
    .fault_code (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive phase ph (0..3) or an illegal pair for one sample, then settle past the edge
  task automatic tick_raw(input logic [2:0] a, input logic [2:0] b, input logic clr);
    @(negedge clk);
    LightA    = a;
    LightB    = b;
    fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int ph);
    case (ph)
      0:       tick_raw(3'b001, 3'b100, 1'b0);
      1:       tick_raw(3'b010, 3'b100, 1'b0);
      2:       tick_raw(3'b100, 3'b001, 1'b0);
      default: tick_raw(3'b100, 3'b010, 1'b0);
    endcase
  endtask

  task automatic tick_clr(input int ph);
    case (ph)
      0:       tick_raw(3'b001, 3'b100, 1'b1);
      1:       tick_raw(3'b010, 3'b100, 1'b1);
      2:       tick_raw(3'b100, 3'b001, 1'b1);
      default: tick_raw(3'b100, 3'b010, 1'b1);
    endcase
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, 8'(phase), 8'd0);
    chk({tag, "_remain"}, 8'(remain), 8'd0);
    chk({tag, "_locked"}, 8'(locked), 8'd0);
    chk({tag, "_cdone"}, 8'(cycle_done), 8'd0);
    chk({tag, "_fault"}, 8'(fault), 8'd0);
    chk({tag, "_code"}, 8'(fault_code), 8'd0);
  endtask

  initial begin
    int lens [4];
    lens[0] = 8; lens[1] = 3; lens[2] = 10; lens[3] = 3;
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    LightA    = 3'b001;
    LightB    = 3'b100;
    fault_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // Nominal: three full cycles from a common reset release
    for (int cyc = 0; cyc < 3; cyc++) begin
      for (int ph = 0; ph < 4; ph++) begin
        for (int k = 0; k < lens[ph]; k++) begin
          tick(ph);
          chk("nom_phase", 8'(phase), 8'(ph));
          chk("nom_fault", 8'(fault), 8'd0);
          chk("nom_cdone", 8'(cycle_done), 8'((cyc > 0) && (ph == 0) && (k == 0)));
          if (cyc == 0 && ph == 0) begin
            chk("nom_sync_locked", 8'(locked), 8'd0);
            chk("nom_sync_remain", 8'(remain), 8'd0);
          end else begin
            chk("nom_locked", 8'(locked), 8'd1);
            chk("nom_remain", 8'(remain), 8'(lens[ph] - 1 - k));
          end
        end
      end
    end
    tick(0);
    chk("edge73_cdone", 8'(cycle_done), 8'd1);
    chk("edge73_remain", 8'(remain), 8'd7);
    tick(0);
    chk("cdone_one_cycle", 8'(cycle_done), 8'd0);
    repeat (6) tick(0);
    chk("p0_last_remain", 8'(remain), 8'd0);

    // Both-green illegal pattern while locked
    tick_raw(3'b001, 3'b001, 1'b0);
    chk("ill_fault", 8'(fault), 8'd1);
    chk("ill_code", 8'(fault_code), 8'd1);
    chk("ill_locked", 8'(locked), 8'd0);
    chk("ill_remain", 8'(remain), 8'd0);
    chk("ill_phase_held", 8'(phase), 8'd0);
    tick(0);
    tick(1);
    chk("ill_sticky_code", 8'(fault_code), 8'd1);
    chk("fault_tracks_phase", 8'(phase), 8'd1);

    tick_clr(1);
    chk("clr_fault", 8'(fault), 8'd0);
    chk("clr_code", 8'(fault_code), 8'd0);

    // Short P0 after relocking at P1->P2
    tick(1);
    chk("sync_after_clr", 8'(locked), 8'd0);
    tick(2);
    chk("short_lock", 8'(locked), 8'd1);
    chk("short_lock_remain", 8'(remain), 8'd9);
    repeat (9) tick(2);
    repeat (3) tick(3);
    tick(0);
    chk("short_pre_cdone", 8'(cycle_done), 8'd1);
    repeat (4) tick(0);
    chk("short_pre_remain", 8'(remain), 8'd3);
    tick(1);
    chk("short_fault", 8'(fault), 8'd1);
    chk("short_code", 8'(fault_code), 8'd3);
    chk("short_locked", 8'(locked), 8'd0);

    // Long P1
    tick_clr(1);
    tick(0);
    tick(1);
    chk("long_lock_remain", 8'(remain), 8'd2);
    tick(1);
    tick(1);
    chk("long_last_remain", 8'(remain), 8'd0);
    chk("long_no_fault_yet", 8'(fault), 8'd0);
    tick(1);
    chk("long_code", 8'(fault_code), 8'd4);
    chk("long_locked", 8'(locked), 8'd0);

    // Order: P0 jumps straight to P2 in SYNC
    tick_clr(1);
    tick(0);
    tick(2);
    chk("order_fault", 8'(fault), 8'd1);
    chk("order_code", 8'(fault_code), 8'd2);

    // Clear collides with an illegal sample
    tick_raw(3'b100, 3'b100, 1'b1);
    chk("coll_fault", 8'(fault), 8'd0);
    chk("coll_code", 8'(fault_code), 8'd0);
    chk("coll_locked", 8'(locked), 8'd0);
    repeat (3) tick(0);
    chk("coll_sync", 8'(locked), 8'd0);
    tick(1);
    chk("coll_relock", 8'(locked), 8'd1);
    chk("coll_relock_remain", 8'(remain), 8'd2);
    chk("coll_relock_fault", 8'(fault), 8'd0);

    // Mid-run reset during P2
    repeat (2) tick(1);
    repeat (4) tick(2);
    chk("pre_rst_remain", 8'(remain), 8'd6);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick(2);
    chk("rst_sync_locked", 8'(locked), 8'd0);
    chk("rst_sync_phase", 8'(phase), 8'd2);
    tick(3);
    chk("rst_relock", 8'(locked), 8'd1);
    chk("rst_relock_remain", 8'(remain), 8'd2);
    chk("rst_relock_fault", 8'(fault), 8'd0);
    repeat (2) tick(3);
    tick(0);
    chk("rst_cdone", 8'(cycle_done), 8'd1);
    chk("rst_final_fault", 8'(fault), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
